hmc_tile_engine: RTL and testbench



---
 rtl/hmc_tile_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_hmc_tile_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmc_tile_engine.sv
// Tiled HMC pixel engine: tagged read bursts into a reorder buffer, per-lane op,
// then in-order writes of the processed flits.
module hmc_tile_engine #(
    parameter int          TAG_WIDTH   = 6,
    parameter int          ADDR_WIDTH  = 34,
    parameter int          DATA_WIDTH  = 128,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          BURST       = 32,
    parameter logic [3:0]  HMC_CMD_RD  = 4'h6,
    parameter logic [3:0]  HMC_CMD_WR  = 4'h8
) (
    input  logic                   rx_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [31:0]            work_size,
    input  logic [1:0]             mode,
    input  logic [PIXEL_WIDTH-1:0] param,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [3:0]             cmd,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [3:0]             size,
    output logic [TAG_WIDTH-1:0]   tag,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_data_valid,
    input  logic                   wr_data_ready,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic [TAG_WIDTH-1:0]   rd_data_tag,
    input  logic                   rd_data_valid,
    output logic                   busy,
    output logic                   finished,
    output logic [31:0]            flits_done,
    output logic [7:0]             err_count
);
    localparam int LANES = DATA_WIDTH / PIXEL_WIDTH;
    localparam int BW    = $clog2(BURST + 1);
    localparam int IW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [ADDR_WIDTH-1:0] FLIT_BYTES = ADDR_WIDTH'(16);

    typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, WRITE, DONE} state_e;

    function automatic logic [BW-1:0] batch_of(input logic [31:0] rem);
        if (rem > 32'(BURST)) batch_of = BW'(BURST);
        else                  batch_of = rem[BW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pixel_op(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] m,
                                                       input logic [PIXEL_WIDTH-1:0] p);
        logic [PIXEL_WIDTH-1:0] px;
        logic [PIXEL_WIDTH:0]   sum;
        pixel_op = '0;
        for (int l = 0; l < LANES; l++) begin
            px  = d[l*PIXEL_WIDTH +: PIXEL_WIDTH];
            sum = {1'b0, px} + {1'b0, p};
            case (m)
                2'd0:    pixel_op[l*PIXEL_WIDTH +: PIXEL_WIDTH] = px;
                2'd1:    pixel_op[l*PIXEL_WIDTH +: PIXEL_WIDTH] = ~px;
                2'd2:    pixel_op[l*PIXEL_WIDTH +: PIXEL_WIDTH] = (px >= p) ? '1 : '0;
                2'd3:    pixel_op[l*PIXEL_WIDTH +: PIXEL_WIDTH] = sum[PIXEL_WIDTH] ? '1 : sum[PIXEL_WIDTH-1:0];
                default: pixel_op[l*PIXEL_WIDTH +: PIXEL_WIDTH] = px;
            endcase
        end
    endfunction

    state_e                  state_q, state_d;
    logic                    en_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]             rem_q, rem_d;
    logic [1:0]              mode_q, mode_d;
    logic [PIXEL_WIDTH-1:0]  param_q, param_d;
    logic [BW-1:0]           batch_q, batch_d, idx_q, idx_d, rcv_q, rcv_d;
    logic [BURST-1:0]        bvalid_q, bvalid_d;
    logic                    busy_q, busy_d, finished_q, finished_d;
    logic [31:0]             flits_q, flits_d;
    logic [7:0]              err_q, err_d;
    logic                    cmd_valid_q, cmd_valid_d, wdv_q, wdv_d;
    logic [3:0]              cmd_q, cmd_d, size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   rob_q [BURST];

    logic [IW-1:0]           rtag_idx_s;
    logic [BW-1:0]           idx_inc_s;
    logic                    resp_ok_s, resp_err_s, rd_phase_s;

    // Response classification: only in-batch, first-seen tags during the read phase are kept
    always_comb begin
        rtag_idx_s = rd_data_tag[IW-1:0];
        idx_inc_s  = idx_q + BW'(1);
        rd_phase_s = (state_q == ISSUE_RD) || (state_q == WAIT_RD);
        resp_ok_s  = rd_data_valid && rd_phase_s &&
                     ({1'b0, rd_data_tag} < (TAG_WIDTH+1)'(batch_q)) && !bvalid_q[rtag_idx_s];
        resp_err_s = rd_data_valid && !resp_ok_s;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;   rd_ptr_d = rd_ptr_q;   wr_ptr_d = wr_ptr_q;  rem_d = rem_q;
        mode_d = mode_q;     param_d = param_q;     batch_d = batch_q;    idx_d = idx_q;
        rcv_d = rcv_q;       bvalid_d = bvalid_q;   busy_d = busy_q;      finished_d = finished_q;
        flits_d = flits_q;   err_d = err_q;         cmd_valid_d = cmd_valid_q;
        wdv_d = wdv_q;       cmd_d = cmd_q;         size_d = size_q;      addr_d = addr_q;
        tag_d = tag_q;       wr_data_d = wr_data_q;

        if (resp_ok_s) begin
            bvalid_d[rtag_idx_s] = 1'b1;
            rcv_d = rcv_q + BW'(1);
        end else if (resp_err_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                if (enable && !en_q) begin
                    rd_ptr_d = src_addr;  wr_ptr_d = dst_addr;  rem_d = work_size;
                    mode_d = mode;        param_d = param;      flits_d = 32'd0;
                    idx_d = '0;           rcv_d = '0;           bvalid_d = '0;
                    batch_d = batch_of(work_size);
                    if (work_size == 32'd0) begin
                        state_d = DONE;  finished_d = 1'b1;  busy_d = 1'b0;
                    end else begin
                        state_d = ISSUE_RD;  busy_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_RD, WAIT_RD, WRITE: begin
                if (!enable) begin
                    state_d = IDLE;  cmd_valid_d = 1'b0;  wdv_d = 1'b0;
                    bvalid_d = '0;   rcv_d = '0;          busy_d = 1'b0;
                end else if (state_q == WAIT_RD) begin
                    if (rcv_q == batch_q) begin
                        state_d = WRITE;  idx_d = '0;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (!cmd_valid_q) begin
                    // First presentation of the current flit, one cycle after state entry
                    cmd_valid_d = 1'b1;  size_d = 4'd1;
                    if (state_q == ISSUE_RD) begin
                        cmd_d = HMC_CMD_RD;  addr_d = rd_ptr_q;  tag_d = TAG_WIDTH'(idx_q);
                    end else begin
                        cmd_d = HMC_CMD_WR;  addr_d = wr_ptr_q;  wdv_d = 1'b1;
                        wr_data_d = pixel_op(rob_q[idx_q[IW-1:0]], mode_q, param_q);
                    end
                end else if (state_q == ISSUE_RD) begin
                    if (cmd_ready) begin
                        rd_ptr_d = rd_ptr_q + FLIT_BYTES;  idx_d = idx_inc_s;
                        if (idx_q == batch_q - BW'(1)) begin
                            cmd_valid_d = 1'b0;  state_d = WAIT_RD;
                        end else begin
                            addr_d = rd_ptr_q + FLIT_BYTES;  tag_d = TAG_WIDTH'(idx_inc_s);
                        end
                    end else begin
                        state_d = ISSUE_RD;
                    end
                end else if (cmd_ready && wr_data_ready) begin
                    wr_ptr_d = wr_ptr_q + FLIT_BYTES;  flits_d = flits_q + 32'd1;
                    rem_d = rem_q - 32'd1;             idx_d = idx_inc_s;
                    if (idx_q == batch_q - BW'(1)) begin
                        cmd_valid_d = 1'b0;  wdv_d = 1'b0;  bvalid_d = '0;
                        rcv_d = '0;          idx_d = '0;
                        if (rem_q == 32'd1) begin
                            state_d = DONE;  busy_d = 1'b0;  finished_d = 1'b1;
                        end else begin
                            state_d = ISSUE_RD;  batch_d = batch_of(rem_q - 32'd1);
                        end
                    end else begin
                        addr_d = wr_ptr_q + FLIT_BYTES;
                        wr_data_d = pixel_op(rob_q[idx_inc_s[IW-1:0]], mode_q, param_q);
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;  finished_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reorder buffer payload storage
    always_ff @(posedge rx_clk) begin
        if (resp_ok_s) rob_q[rtag_idx_s] <= rd_data;
    end

    // Control and output registers
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;     en_q <= 1'b0;       rd_ptr_q <= '0;     wr_ptr_q <= '0;
            rem_q <= 32'd0;      mode_q <= 2'd0;     param_q <= '0;      batch_q <= '0;
            idx_q <= '0;         rcv_q <= '0;        bvalid_q <= '0;     busy_q <= 1'b0;
            finished_q <= 1'b0;  flits_q <= 32'd0;   err_q <= 8'd0;      cmd_valid_q <= 1'b0;
            wdv_q <= 1'b0;       cmd_q <= 4'd0;      size_q <= 4'd0;     addr_q <= '0;
            tag_q <= '0;         wr_data_q <= '0;
        end else begin
            state_q <= state_d;        en_q <= enable;        rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;      rem_q <= rem_d;        mode_q <= mode_d;
            param_q <= param_d;        batch_q <= batch_d;    idx_q <= idx_d;
            rcv_q <= rcv_d;            bvalid_q <= bvalid_d;  busy_q <= busy_d;
            finished_q <= finished_d;  flits_q <= flits_d;    err_q <= err_d;
            cmd_valid_q <= cmd_valid_d; wdv_q <= wdv_d;       cmd_q <= cmd_d;
            size_q <= size_d;          addr_q <= addr_d;      tag_q <= tag_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd           = cmd_q;
    assign addr          = addr_q;
    assign size          = size_q;
    assign tag           = tag_q;
    assign wr_data       = wr_data_q;
    assign wr_data_valid = wdv_q;
    assign busy          = busy_q;
    assign finished      = finished_q;
    assign flits_done    = flits_q;
    assign err_count     = err_count_w();

    function automatic logic [7:0] err_count_w();
        err_count_w = err_q;
    endfunction
endmodule

// File: tb/tb_hmc_tile_engine.sv
// Scoreboard bench for hmc_tile_engine: expected commands are queued per job and
// popped as the DUT's commands are accepted; a small memory model answers reads.
module tb_hmc_tile_engine;
    localparam int TW = 6, AW = 34, DW = 128, PW = 8, BURST = 32, LANES = DW / PW;
    localparam logic [3:0] CMD_RD = 4'h6, CMD_WR = 4'h8;

    logic rx_clk, rst_n, enable;
    logic [AW-1:0] src_addr, dst_addr;
    logic [31:0] work_size;
    logic [1:0] mode;
    logic [PW-1:0] param;
    logic cmd_valid, cmd_ready, wr_data_valid, wr_data_ready, rd_data_valid, busy, finished;
    logic [3:0] cmd, size;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag, rd_data_tag;
    logic [DW-1:0] wr_data, rd_data;
    logic [31:0] flits_done;
    logic [7:0] err_count;

    hmc_tile_engine dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .enable(enable), .src_addr(src_addr),
        .dst_addr(dst_addr), .work_size(work_size), .mode(mode), .param(param),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr), .size(size),
        .tag(tag), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready), .rd_data(rd_data), .rd_data_tag(rd_data_tag),
        .rd_data_valid(rd_data_valid), .busy(busy), .finished(finished),
        .flits_done(flits_done), .err_count(err_count)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t exp_q[$];
    int n_checks = 0, n_pass = 0, err_exp = 0, pat = 0;
    logic [DW-1:0] last_wr;

    task automatic chk_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (pat)
            0:       return {8{16'h00FF}};
            1:       return {a[31:0] * 32'h9E37_79B1, ~a[31:0], a[31:0] ^ 32'hA5A5_5A5A, a[31:0] + 32'h1234_5678};
            2:       return {16{8'hF8}};
            default: return {8{16'h807F}};
        endcase
    endfunction

    function automatic logic [DW-1:0] model_op(input logic [DW-1:0] d, input logic [1:0] m, input logic [PW-1:0] p);
        logic [DW-1:0] r;
        int v, pv;
        r = '0;
        pv = int'(p);
        for (int l = 0; l < LANES; l++) begin
            v = int'(d[l*PW +: PW]);
            case (m)
                2'd0:    r[l*PW +: PW] = d[l*PW +: PW];
                2'd1:    r[l*PW +: PW] = 8'(255 - v);
                2'd2:    r[l*PW +: PW] = (v >= pv) ? 8'hFF : 8'h00;
                default: r[l*PW +: PW] = (v + pv > 255) ? 8'hFF : 8'(v + pv);
            endcase
        end
        return r;
    endfunction

    // order: 0 in-order, 1 reverse (+dup and tag 40 on a 6-flit batch), 2 none
    // rdy: 0 always ready, 1 random, 2 stall first write 5 cycles
    // stop: 0 run to DONE, 1 abort in WAIT_RD, 2 reset during WRITE
    task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input int ws,
                           input logic [1:0] m, input logic [PW-1:0] p,
                           input int order, input int rdy, input int stop);
        cmd_t e;
        logic [TW-1:0] pend[$];
        logic [AW-1:0] tag_addr [64];
        logic [DW-1:0] held_data;
        logic [AW-1:0] held_addr;
        logic [TW-1:0] t;
        int base = 0, cur_batch, issued = 0, delivered = 0, written = 0;
        int inj = 0, stall = 0, cyc = 0, wcnt = 0;
        bit done = 0;
        exp_q.delete();
        for (int b = 0; b < ws; b += BURST) begin
            int bs;
            bs = (ws - b > BURST) ? BURST : ws - b;
            for (int i = 0; i < bs; i++)
                exp_q.push_back('{CMD_RD, s + AW'((b + i) * 16), TW'(i), '0});
            for (int i = 0; i < bs; i++)
                exp_q.push_back('{CMD_WR, d + AW'((b + i) * 16), '0,
                                  model_op(mem_word(s + AW'((b + i) * 16)), m, p)});
        end
        cur_batch = (ws > BURST) ? BURST : ws;
        src_addr = s; dst_addr = d; work_size = 32'(ws); mode = m; param = p;
        enable = 1'b1;
        while (!done && cyc < 5000) begin
            @(negedge rx_clk);
            cyc++;
            rd_data_valid = 1'b0;
            if (cyc == 1 && ws > 0) chk_eq("busy_start", busy, 1);
            if (finished) begin
                done = 1;
            end else begin
                if (order == 0 && pend.size() > 0) begin
                    t = pend.pop_front();
                    rd_data_tag = t; rd_data = mem_word(tag_addr[t]); rd_data_valid = 1'b1;
                    delivered++;
                end else if (order == 1 && issued == cur_batch && cur_batch > 0) begin
                    if (inj == 1) begin
                        rd_data = ~mem_word(tag_addr[rd_data_tag]); rd_data_valid = 1'b1;
                        inj = 2; err_exp++;
                    end else if (inj == 2) begin
                        rd_data_tag = 6'd40; rd_data = '1; rd_data_valid = 1'b1;
                        inj = 3; err_exp++;
                    end else if (pend.size() > 0) begin
                        t = pend.pop_back();
                        rd_data_tag = t; rd_data = mem_word(tag_addr[t]); rd_data_valid = 1'b1;
                        delivered++;
                        if (inj == 0 && cur_batch == 6) inj = 1;
                    end
                end
                case (rdy)
                    1: begin
                        cmd_ready = 1'($urandom_range(0, 1));
                        wr_data_ready = 1'($urandom_range(0, 1));
                    end
                    2: begin
                        if (cmd_valid && cmd == CMD_WR && stall < 5) begin
                            wr_data_ready = 1'b0;
                            cmd_ready = (stall % 2 == 1);
                            if (stall == 0) begin
                                held_data = wr_data; held_addr = addr;
                            end else begin
                                chk_eq("wr_hold_data", wr_data, held_data);
                                chk_eq("wr_hold_addr", addr, held_addr);
                                chk_eq("wr_hold_valid", {cmd_valid, wr_data_valid}, 2'b11);
                            end
                            if (stop == 2 && stall == 2) begin
                                rst_n = 1'b0;
                                #1;
                                chk_eq("rst_cmd_valid", cmd_valid, 0);
                                chk_eq("rst_wdv", wr_data_valid, 0);
                                chk_eq("rst_busy", busy, 0);
                                chk_eq("rst_addr", addr, 0);
                                chk_eq("rst_wr_data", wr_data, 0);
                                chk_eq("rst_flits", flits_done, 0);
                                enable = 1'b0; err_exp = 0;
                                @(negedge rx_clk);
                                rst_n = 1'b1;
                                done = 1;
                            end
                            stall++;
                        end else begin
                            cmd_ready = 1'b1; wr_data_ready = 1'b1;
                        end
                    end
                    default: begin
                        cmd_ready = 1'b1; wr_data_ready = 1'b1;
                    end
                endcase
                if (!done && stop == 1 && issued == cur_batch) begin
                    wcnt++;
                    if (wcnt == 3) begin
                        enable = 1'b0;
                        @(negedge rx_clk);
                        chk_eq("abort_cmd_valid", cmd_valid, 0);
                        chk_eq("abort_wdv", wr_data_valid, 0);
                        chk_eq("abort_busy", busy, 0);
                        chk_eq("abort_flits", flits_done, 0);
                        rd_data_tag = 6'd0; rd_data = '0; rd_data_valid = 1'b1;
                        err_exp++;
                        @(negedge rx_clk);
                        rd_data_valid = 1'b0;
                        done = 1;
                    end
                end
                if (!done && cmd_valid && cmd_ready && (cmd != CMD_WR || wr_data_ready)) begin
                    if (exp_q.size() == 0) begin
                        chk_eq("unexpected_cmd", {cmd, addr}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_eq("cmd", cmd, e.cmd);
                        chk_eq("addr", addr, e.addr);
                        if (e.cmd == CMD_RD) begin
                            chk_eq("rd_tag", tag, e.tag);
                            chk_eq("size", size, 1);
                            tag_addr[tag] = addr;
                            pend.push_back(tag);
                            issued++;
                        end else begin
                            chk_eq("wr_data", wr_data, e.data);
                            chk_eq("wr_after_all_rsp", delivered, cur_batch);
                            last_wr = wr_data;
                            written++;
                            if (written == cur_batch) begin
                                base += cur_batch;
                                cur_batch = (ws - base > BURST) ? BURST : ws - base;
                                issued = 0; delivered = 0; written = 0; inj = 0;
                            end
                        end
                    end
                end
            end
        end
        rd_data_valid = 1'b0;
        if (stop == 0) begin
            chk_eq("job_in_time", done, 1);
            chk_eq("sb_empty", exp_q.size(), 0);
            chk_eq("finished", finished, 1);
            chk_eq("busy_done", busy, 0);
            chk_eq("flits_done", flits_done, ws);
            chk_eq("err_count", err_count, err_exp);
            enable = 1'b0;
            @(negedge rx_clk);
            @(negedge rx_clk);
            chk_eq("finished_clr", finished, 0);
        end
    endtask

    initial begin
        rx_clk = 1'b0; rst_n = 1'b0; enable = 1'b0;
        src_addr = '0; dst_addr = '0; work_size = 32'd0; mode = 2'd0; param = '0;
        cmd_ready = 1'b0; wr_data_ready = 1'b0; rd_data = '0; rd_data_tag = '0; rd_data_valid = 1'b0;
        repeat (3) @(negedge rx_clk);
        chk_eq("reset_outputs", {cmd_valid, wr_data_valid, busy, finished, cmd, size, tag}, 0);
        chk_eq("reset_counters", {flits_done, err_count, addr}, 0);
        chk_eq("reset_wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(negedge rx_clk);
        chk_eq("idle_after_reset", {busy, finished, cmd_valid}, 0);

        pat = 0; run_job(34'h0_0000_1000, 34'h0_0000_8000, 4, 2'd1, 8'h00, 0, 0, 0);
        chk_eq("kat_invert", last_wr, {8{16'hFF00}});
        pat = 1; run_job(34'h3_FFFF_FF00, 34'h0_0002_0000, 70, 2'd0, 8'h00, 0, 1, 0);
        pat = 1; run_job(34'h0_0010_0000, 34'h0_0020_0000, 38, 2'd1, 8'h00, 1, 0, 0);
        chk_eq("err_after_reorder", err_count, 2);
        pat = 2; run_job(34'h0_0030_0000, 34'h0_0040_0000, 3, 2'd3, 8'h10, 0, 0, 0);
        chk_eq("kat_sat_add", last_wr, {16{8'hFF}});
        pat = 3; run_job(34'h0_0050_0000, 34'h0_0060_0000, 2, 2'd2, 8'h80, 0, 1, 0);
        chk_eq("kat_threshold", last_wr, {8{16'hFF00}});
        pat = 1; run_job(34'h0_0070_0000, 34'h0_0080_0000, 5, 2'd3, 8'h40, 0, 1, 0);
        pat = 1; run_job(34'h0_0090_0000, 34'h0_00A0_0000, 3, 2'd1, 8'h00, 0, 2, 0);
        pat = 1; run_job(34'h0_00B0_0000, 34'h0_00C0_0000, 8, 2'd1, 8'h00, 2, 0, 1);
        pat = 1; run_job(34'h0_00B0_0000, 34'h0_00C0_0000, 8, 2'd1, 8'h00, 0, 0, 0);
        pat = 1; run_job(34'h0_00D0_0000, 34'h0_00E0_0000, 0, 2'd0, 8'h00, 0, 0, 0);
        pat = 1; run_job(34'h0_00F0_0000, 34'h0_0100_0000, 4, 2'd1, 8'h00, 0, 2, 2);
        @(negedge rx_clk);
        chk_eq("post_reset_err", err_count, 0);
        pat = 1; run_job(34'h0_0110_0000, 34'h0_0120_0000, 2, 2'd2, 8'h55, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
